// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the register-file writeback arbiter.
//   DATA_W / ADDR_W : default widths of write data and register address
//   REG_ZERO        : hard-wired zero register; writes to it are dropped
//   wb_entry_t      : one buffered writeback {v, addr, data}
//   src_hit()       : true when a live write targets a decode source register
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // A write to REG_ZERO never produces a value, so it can never be a hazard,
  // even when decode is reading register 0.
  function automatic logic src_hit(input logic              v,
                                   input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] rd1,
                                   input logic [ADDR_W-1:0] rd2);
    return v && (addr != REG_ZERO) && ((addr == rd1) || (addr == rd2));
  endfunction

endpackage

// File: rtl/wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
//   One-entry writeback holding buffer with a valid/ready input handshake.
//   The entry is drained when the arbiter grants it; a new request may be
//   accepted on the same edge the current entry drains (full throughput).
//   Ports:
//     clk, rst   clock, synchronous active-low reset
//     in_valid   request from the writeback source
//     in_addr    destination register of the request
//     in_data    write data of the request
//     drain      arbiter grant: entry leaves on this edge
//     ready      request is accepted this cycle when in_valid && ready
//     load       accept happening on this edge (in_valid && ready)
//     entry      current buffered entry
// -----------------------------------------------------------------------------
module wb_slot
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              ready,
  output logic              load,
  output wb_entry_t         entry
);

  wb_entry_t ent_q, ent_d;

  always_comb begin
    // Nothing is accepted while reset is held.
    ready = rst && (!ent_q.v || drain);
    load  = in_valid && ready;
    ent_d = ent_q;
    if (load) begin
      // A load on a draining edge simply replaces the leaving entry.
      ent_d.v    = 1'b1;
      ent_d.addr = in_addr;
      ent_d.data = in_data;
    end else if (drain) begin
      ent_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ent_q <= '0;
    else      ent_q <= ent_d;
  end

  assign entry = ent_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU (wb0) and the
//   memory/load path (wb1). Each source has a one-entry buffer (wb_slot);
//   buffered writes drain oldest-first so same-register writes commit in
//   program order. Also flags a decode read hazard while a write to a decode
//   source register is buffered or on the write port.
//   Ports:
//     clk, rst               clock, synchronous active-low reset
//     wb0_valid/ready/addr/data   ALU writeback handshake
//     wb1_valid/ready/addr/data   memory writeback handshake
//     ReadReg1, ReadReg2     decode-stage source registers
//     regWrite, WriteReg, writeData   registered register-file write port
//     hazard                 combinational read hazard to decode
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] writeData,
  output logic              hazard
);

  wb_entry_t buf0, buf1, gnt_e;
  logic      load0, load1;
  logic      grant0, grant1;

  logic              old1_q, old1_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // ---------------------------------------------------------------------------
  // Per-source holding buffers
  // ---------------------------------------------------------------------------
  wb_slot u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wb0_valid),
    .in_addr  (wb0_addr),
    .in_data  (wb0_data),
    .drain    (grant0),
    .ready    (wb0_ready),
    .load     (load0),
    .entry    (buf0)
  );

  wb_slot u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wb1_valid),
    .in_addr  (wb1_addr),
    .in_data  (wb1_data),
    .drain    (grant1),
    .ready    (wb1_ready),
    .load     (load1),
    .entry    (buf1)
  );

  // ---------------------------------------------------------------------------
  // Grant: a lone valid buffer always wins; with both valid the older wins.
  // Because one buffer drains every cycle both are valid, the loser waits at
  // most one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = buf0.v && (!buf1.v || !old1_q);
    grant1 = buf1.v && (!buf0.v ||  old1_q);
    gnt_e  = grant1 ? buf1 : buf0;
  end

  // ---------------------------------------------------------------------------
  // Age flag: old1 means buf1 holds the older of the two entries.
  //  - both loaded together: the load came out of the longer pipe, so it is
  //    the older instruction -> buf1 older.
  //  - one buffer reloads while the other one stays put: the entry that stays
  //    is the older one.
  //  - a load into an otherwise empty pair leaves only one valid entry, so
  //    the flag value does not matter until the other side loads.
  // ---------------------------------------------------------------------------
  always_comb begin
    old1_d = old1_q;
    if (load0 && load1)                    old1_d = 1'b1;
    else if (load1 && buf0.v && !grant0)   old1_d = 1'b0;
    else if (load0 && buf1.v && !grant1)   old1_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write port register. A write to REG_ZERO is consumed from its buffer but
  // never raises regWrite. With no grant the address/data hold their values.
  // ---------------------------------------------------------------------------
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant0 || grant1) begin
      regwrite_d   = (gnt_e.addr != REG_ZERO);
      write_reg_d  = gnt_e.addr;
      write_data_d = gnt_e.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      old1_q       <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      old1_q       <= old1_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign regWrite  = regwrite_q;
  assign WriteReg  = write_reg_q;
  assign writeData = write_data_q;

  // ---------------------------------------------------------------------------
  // Read hazard: any buffered write, or the write on the port this cycle (the
  // register file only commits it at the end of the cycle), that targets a
  // decode source register.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard = rst && (src_hit(buf0.v, buf0.addr, ReadReg1, ReadReg2) ||
                     src_hit(buf1.v, buf1.addr, ReadReg1, ReadReg2) ||
                     src_hit(regwrite_q, write_reg_q, ReadReg1, ReadReg2));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Self-checking bench. The reference model tracks pending writes as
//   {addr, data, arrival sequence} and always drains the lowest sequence
//   number; a register file driven from the DUT write port is compared
//   against the model's register file and against hand-computed values.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic        wb0_ready, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr, ReadReg1, ReadReg2, WriteReg;
  logic [31:0] wb0_data, wb1_data, writeData;
  logic        regWrite, hazard;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb0_valid (wb0_valid),
    .wb0_ready (wb0_ready),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_ready (wb1_ready),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .regWrite  (regWrite),
    .WriteReg  (WriteReg),
    .writeData (writeData),
    .hazard    (hazard)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file fed by the DUT write port.
  logic [31:0] rf [32] = '{default: '0};
  always @(posedge clk)
    if (regWrite && WriteReg != 5'd0) rf[WriteReg] <= writeData;

  // ---------------------------------------------------------------------------
  // Reference model: pending writes with arrival order.
  // ---------------------------------------------------------------------------
  bit          m_v    [2] = '{0, 0};
  logic [4:0]  m_addr [2] = '{default: '0};
  logic [31:0] m_data [2] = '{default: '0};
  int unsigned m_seq  [2] = '{0, 0};
  int unsigned seq_ctr = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] mrf [32] = '{default: '0};

  function automatic int oldest();
    if (m_v[0] && m_v[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready(input int k);
    return rst && (!m_v[k] || oldest() == k);
  endfunction

  function automatic bit hit(input bit v, input logic [4:0] a);
    return v && a != 5'd0 && (a == ReadReg1 || a == ReadReg2);
  endfunction

  function automatic bit exp_hazard();
    return rst && (hit(m_v[0], m_addr[0]) || hit(m_v[1], m_addr[1]) || hit(m_we, m_wa));
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit a0, a1;
    if (!rst) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      g  = oldest();
      a0 = wb0_valid && exp_ready(0);
      a1 = wb1_valid && exp_ready(1);
      if (g >= 0) begin
        m_wa = m_addr[g];
        m_wd = m_data[g];
        m_we = (m_addr[g] != 5'd0);
        m_v[g] = 1'b0;
        if (m_we) mrf[m_wa] = m_wd;
      end else begin
        m_we = 1'b0;
      end
      // Loads arriving together: the memory one is the older instruction.
      if (a1) begin
        m_v[1] = 1'b1; m_addr[1] = wb1_addr; m_data[1] = wb1_data; m_seq[1] = seq_ctr; seq_ctr++;
      end
      if (a0) begin
        m_v[0] = 1'b1; m_addr[0] = wb0_addr; m_data[0] = wb0_data; m_seq[0] = seq_ctr; seq_ctr++;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb0_ready", 32'(wb0_ready), 32'(exp_ready(0)));
      chk("wb1_ready", 32'(wb1_ready), 32'(exp_ready(1)));
      chk("regWrite",  32'(regWrite),  32'(m_we));
      chk("WriteReg",  32'(WriteReg),  32'(m_wa));
      chk("writeData", writeData,      m_wd);
      chk("hazard",    32'(hazard),    32'(exp_hazard()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  task automatic cmp_rf(input string name);
    for (int r = 0; r < 32; r++) chk(name, rf[r], mrf[r]);
  endtask

  initial begin
    int n0, n1, wcnt;
    bit r0, r1;
    rst = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // 1: reset held two cycles with a request pending
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_wb0_ready", 32'(wb0_ready), 32'd0);
    chk("rst_regWrite",  32'(regWrite),  32'd0);
    chk("rst_WriteReg",  32'(WriteReg),  32'd0);
    chk("rst_writeData", writeData,      32'd0);
    step();
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    chk("rel_wb0_ready", 32'(wb0_ready), 32'd1);

    // 2: single ALU write
    step();
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hA5A5A5A5;
    step();
    idle_in();
    @(negedge clk);
    chk("t2_buffered_regWrite", 32'(regWrite), 32'd0);
    step();
    @(negedge clk);
    chk("t2_regWrite", 32'(regWrite), 32'd1);
    chk("t2_WriteReg", 32'(WriteReg), 32'd5);
    step();
    @(negedge clk);
    chk("t2_rf5", rf[5], 32'hA5A5A5A5);

    // 3: same register from both sources, simultaneous then staggered
    step();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h2;
    step();
    idle_in();
    step();
    @(negedge clk);
    chk("t3_first_data", writeData, 32'h2);
    step();
    @(negedge clk);
    chk("t3_second_data", writeData, 32'h1);
    repeat (2) step();
    chk("t3_rf7", rf[7], 32'h1);
    chk("t3_model_rf7", mrf[7], 32'h1);
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    step();
    wb0_valid = 1'b0;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h2;
    step();
    wb1_valid = 1'b0;
    @(negedge clk);
    chk("t3r_first_data", writeData, 32'h1);
    step();
    @(negedge clk);
    chk("t3r_second_data", writeData, 32'h2);
    repeat (2) step();
    chk("t3r_rf7", rf[7], 32'h2);
    chk("t3r_model_rf7", mrf[7], 32'h2);

    // 4: write to register 0 is consumed but never committed
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'hFFFFFFFF;
    step();
    idle_in();
    @(negedge clk);
    chk("t4_wb1_ready", 32'(wb1_ready), 32'd1);
    step();
    @(negedge clk);
    chk("t4_regWrite", 32'(regWrite), 32'd0);
    step();
    chk("t4_rf0", rf[0], 32'd0);

    // 5: hazard on a pending write; register 0 never flags
    ReadReg1 = 5'd9; ReadReg2 = 5'd0;
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    @(negedge clk);
    chk("t5_hazard_pre", 32'(hazard), 32'd0);
    step();
    idle_in();
    @(negedge clk);
    chk("t5_hazard_buf", 32'(hazard), 32'd1);
    step();
    @(negedge clk);
    chk("t5_hazard_port", 32'(hazard), 32'd1);
    step();
    @(negedge clk);
    chk("t5_hazard_done", 32'(hazard), 32'd0);
    step();
    ReadReg1 = 5'd3; ReadReg2 = 5'd0;
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h5;
    step();
    idle_in();
    @(negedge clk);
    chk("t5_hazard_r0_buf", 32'(hazard), 32'd0);
    step();
    @(negedge clk);
    chk("t5_hazard_r0_port", 32'(hazard), 32'd0);
    step();

    // 6: both sources streaming, distinct addresses
    n0 = 0; n1 = 0; wcnt = 0;
    for (int c = 0; c < 20; c++) begin
      wb0_valid = 1'b1; wb0_addr = 5'(1 + n0 % 15);  wb0_data = $urandom;
      wb1_valid = 1'b1; wb1_addr = 5'(16 + n1 % 15); wb1_data = $urandom;
      ReadReg1 = 5'($urandom_range(0, 31)); ReadReg2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      r0 = wb0_ready; r1 = wb1_ready;
      if (c >= 2 && regWrite) wcnt++;
      step();
      if (r0) n0++;
      if (r1) n1++;
    end
    idle_in();
    chk("t6_write_cycles", 32'(wcnt), 32'd18);
    chk("t6_wb0_accepts", 32'(n0), 32'd10);
    chk("t6_wb1_accepts", 32'(n1), 32'd11);
    repeat (4) step();
    cmp_rf("t6_rf");

    // mid-stream reset drops buffered writes
    for (int c = 0; c < 3; c++) begin
      wb0_valid = 1'b1; wb0_addr = 5'd20; wb0_data = $urandom;
      wb1_valid = 1'b1; wb1_addr = 5'd21; wb1_data = $urandom;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    chk("t6_rst_regWrite",  32'(regWrite), 32'd0);
    chk("t6_rst_WriteReg",  32'(WriteReg), 32'd0);
    chk("t6_rst_writeData", writeData,     32'd0);
    repeat (4) step();
    cmp_rf("t6_rst_rf");

    // random traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 59) != 0);
      wb0_valid = ($urandom_range(0, 9) < 7);
      wb1_valid = ($urandom_range(0, 9) < 7);
      wb0_addr  = 5'($urandom_range(0, 7));
      wb1_addr  = 5'($urandom_range(0, 7));
      wb0_data  = $urandom;
      wb1_data  = $urandom;
      ReadReg1  = 5'($urandom_range(0, 7));
      ReadReg2  = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b1;
    idle_in();
    repeat (4) step();
    cmp_rf("rand_rf");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
